fifo_wr_frontend: RTL and testbench
===================================

// Module: fifo_wr_frontend
// PURPOSE
//  Write-side front end of the async FIFO, in the wclk domain, directly upstream of the
//  write-pointer/full logic and the FIFO memory. Converts a producer valid/ready stream
//  into winc/wdata. Owns a 2-entry skid buffer so in_ready is registered, with no
//  combinational path from wfull or in_valid. Keeps write-side statistics.
// PARAMETERS
//  DSIZE   8   data word width
//  CNT_W   16  width of wr_count and stall_count
// PORTS
//  wclk         in   1      write clock
//  wrst_n       in   1      reset, asynchronous, active-low
//  in_valid     in   1      producer word valid
//  in_ready     out  1      block can accept a word (registered)
//  in_data      in   DSIZE  producer data
//  winc         out  1      write-increment request to pointer/full logic and memory WE
//  wdata        out  DSIZE  word to FIFO memory
//  wfull        in   1      FIFO full; registered flag that may also assert asynchronously
//  stat_clr     in   1      synchronous clear of all statistics
//  wr_count     out  CNT_W  words written, wraps mod 2^CNT_W
//  stall_count  out  CNT_W  cycles with data pending and wfull high, saturating
//  full_seen    out  1      sticky: wfull was sampled high
// BEHAVIOUR
//  - Reset (wrst_n low, async): state=EMPTY, in_ready=0, winc=0, wdata=0, wr_count=0,
//    stall_count=0, full_seen=0. in_ready goes to 1 on the first wclk edge after release.
//  - accept = in_valid & in_ready. pop = main_valid & ~wfull.
//  - winc = pop, combinational.
//    - If wfull asserts mid-cycle, winc falls in the same cycle. The word stays in main.
//    - No loss and no duplication.
//  - wdata = main register. It is held stable while main_valid & wfull.
//  - States: EMPTY (no words), ONE (main valid), TWO (main + skid valid).
//    - EMPTY: accept -> ONE, main <= in_data.
//    - ONE:   accept&pop -> ONE, main <= in_data.
//             accept&!pop -> TWO, skid <= in_data.
//             !accept&pop -> EMPTY.
//             otherwise hold.
//    - TWO:   pop -> ONE, main <= skid. Otherwise hold. accept cannot occur here.
//  - in_ready flop <= (next_state != TWO).
//  - Latency: a word accepted at edge N in EMPTY drives winc=1 and wdata in the cycle after
//    edge N.
//  - Throughput: 1 word/cycle while wfull=0.
//  - Order is strictly FIFO (main before skid).
//  - wr_count: +1 on each edge where winc=1. Wraps.
//  - stall_count: +1 on each edge where main_valid & wfull. Saturates at 2^CNT_W-1.
//  - full_seen: set on any edge where wfull=1. Held until stat_clr.
//  - stat_clr: on the edge, all three statistics go to 0. If it coincides with an increment
//    or set event, clear wins. Does not affect data path or state.
//  - Reset mid-operation: buffered words are discarded and winc drops immediately. Stale
//    data is never written after release.
// STRUCTURE
//  - Package fifo_wr_pkg: state typedef {EMPTY, ONE, TWO} (2 bits) and default DSIZE/CNT_W.
//  - Sub-module fifo_skid_buf: 2-entry buffer, state machine and registered in_ready,
//    with ports in_*, out_valid, out_ready, out_data.
//  - Top: instantiates fifo_skid_buf with out_ready = ~wfull and winc = out_valid & ~wfull.
//    Wrap and saturating counters and the sticky flag live in the top.
// TESTING
//  1. Hold wrst_n low -> in_ready=0, winc=0, counts=0, full_seen=0.
//     Release -> in_ready=1 after first edge.
//  2. wfull=0, in_valid=1 for 8 cycles with data 0x01..0x08 -> winc=1 for 8 consecutive
//     cycles, 1-cycle delayed. wdata=0x01..0x08 in order. wr_count=8.
//  3. Stream with wfull=1 for 3 cycles -> in_ready=0 once 2 words are buffered.
//     stall_count=3, full_seen=1. After wfull=0, all words come out in order with no
//     loss or duplication.
//  4. wfull asserted asynchronously mid-cycle while winc=1 -> winc falls immediately.
//     Word is re-presented and written once after wfull clears.
//  5. CNT_W=4: 20 stall cycles -> stall_count=15 (saturated). stat_clr coincident with
//     winc -> wr_count=0 next cycle.
//  6. wrst_n pulsed low in state TWO (words 0xA1, 0xA2 held) -> winc=0 at once.
//     After release, new words 0x10, 0x11 are written. 0xA1/0xA2 never appear.

Source files
------------

// File: rtl/fifo_wr_pkg.sv
// Shared types and default sizes for the async FIFO write-side front end.
package fifo_wr_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wr_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: main register feeds the consumer, skid absorbs the word
// that arrives while the consumer stalls, so in_ready can come straight from a flop.
module fifo_skid_buf
    import fifo_wr_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF
)
(
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data
);

    wr_state_e        r_state;
    wr_state_e        w_state_nxt;
    logic [DSIZE-1:0] r_main;
    logic [DSIZE-1:0] r_skid;
    logic [DSIZE-1:0] w_main_nxt;
    logic [DSIZE-1:0] w_skid_nxt;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_pop;

    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign in_ready  = r_in_ready;

    assign w_accept  = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    // State and storage; ready looks one step ahead so TWO is never over-filled.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != TWO);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_main_nxt  = in_data;
                end
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    w_main_nxt  = in_data;
                end else if (w_accept) begin
                    w_state_nxt = TWO;
                    w_skid_nxt  = in_data;
                end else if (w_pop) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can happen
                if (w_pop) begin
                    w_state_nxt = ONE;
                    w_main_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/fifo_wr_frontend.sv
// Write-side front end of the async FIFO: valid/ready producer to winc/wdata,
// plus write statistics (wrapping word count, saturating stall count, sticky full).
module fifo_wr_frontend
    import fifo_wr_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
)
(
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] in_data,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    input  logic             wfull,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             full_seen
);

    logic             w_main_valid;
    logic             w_out_ready;
    logic [CNT_W-1:0] r_wr_count;
    logic [CNT_W-1:0] r_stall_count;
    logic             r_full_seen;

    assign w_out_ready = ~wfull;

    fifo_skid_buf #(
        .DSIZE (DSIZE)
    ) u_skid (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (w_main_valid),
        .out_ready (w_out_ready),
        .out_data  (wdata)
    );

    // wfull may rise mid-cycle; gating here drops winc before the edge.
    assign winc = w_main_valid & ~wfull;

    // Statistics; a coincident clear always wins over an increment or set.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wr_count    <= '0;
            r_stall_count <= '0;
            r_full_seen   <= 1'b0;
        end else if (stat_clr) begin
            r_wr_count    <= '0;
            r_stall_count <= '0;
            r_full_seen   <= 1'b0;
        end else begin
            if (winc) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
            if (w_main_valid && wfull && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (wfull) begin
                r_full_seen <= 1'b1;
            end
        end
    end

    assign wr_count    = r_wr_count;
    assign stall_count = r_stall_count;
    assign full_seen   = r_full_seen;

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Bench for fifo_wr_frontend: a queue-based model of the buffered words and
// statistics, checked every cycle, plus directed scenarios with literal expectations.
module tb_fifo_wr_frontend;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        wfull;
    logic        stat_clr;

    logic        in_ready, winc, full_seen;
    logic [7:0]  wdata;
    logic [15:0] wr_count, stall_count;

    logic        in_ready4, winc4, full_seen4;
    logic [7:0]  wdata4;
    logic [3:0]  wr_count4, stall_count4;

    always #5 wclk = ~wclk;

    fifo_wr_frontend #(.DSIZE(8), .CNT_W(16)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .winc(winc), .wdata(wdata), .wfull(wfull),
        .stat_clr(stat_clr), .wr_count(wr_count), .stall_count(stall_count),
        .full_seen(full_seen)
    );

    fifo_wr_frontend #(.DSIZE(8), .CNT_W(4)) dut4 (
        .wclk(wclk), .wrst_n(wrst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .winc(winc4), .wdata(wdata4), .wfull(wfull),
        .stat_clr(stat_clr), .wr_count(wr_count4), .stall_count(stall_count4),
        .full_seen(full_seen4)
    );

    // Model state: words held by the block, words still to send, words written.
    logic [7:0]  q[$];
    logic [7:0]  src[$];
    logic [7:0]  wlog[$];
    bit          m_ready = 1'b0;
    int unsigned m_wr    = 0;
    int unsigned m_stall = 0;
    bit          m_full  = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge wclk);
        #1;
    endtask

    task automatic wait_written(input int n, input int budget);
        int k = 0;
        while (wlog.size() < n && k < budget) begin
            cyc();
            k++;
        end
        chk("wait_written", 32'(wlog.size() >= n), 32'd1);
    endtask

    // Behavioural model: the block is a FIFO of at most two words.
    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            q.delete();
            m_ready = 1'b0;
            m_wr    = 0;
            m_stall = 0;
            m_full  = 1'b0;
        end else begin
            automatic bit         acc = in_valid && m_ready;
            automatic bit         has = (q.size() > 0);
            automatic logic [7:0] din = in_data;
            if (has && !wfull) begin
                wlog.push_back(q.pop_front());
                m_wr++;
            end
            if (has && wfull) m_stall++;
            if (wfull) m_full = 1'b1;
            if (stat_clr) begin
                m_wr    = 0;
                m_stall = 0;
                m_full  = 1'b0;
            end
            if (acc) begin
                q.push_back(din);
                if (src.size() > 0) void'(src.pop_front());
            end
            m_ready = (q.size() < 2);
        end
    end

    // Producer: presents the head of src whenever there is one.
    always @(posedge wclk) begin
        #2;
        in_valid = (src.size() > 0);
        if (src.size() > 0) in_data = src[0];
    end

    // Every-cycle comparison against the model.
    always @(negedge wclk) begin
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("winc", 32'(winc), 32'(q.size() > 0 && !wfull));
        if (q.size() > 0) chk("wdata", 32'(wdata), 32'(q[0]));
        chk("wr_count", 32'(wr_count), m_wr & 32'hFFFF);
        chk("stall_count", 32'(stall_count), (m_stall > 65535) ? 32'd65535 : m_stall);
        chk("full_seen", 32'(full_seen), 32'(m_full));
        chk("winc4", 32'(winc4), 32'(q.size() > 0 && !wfull));
        chk("wr_count4", 32'(wr_count4), m_wr & 32'hF);
        chk("stall_count4", 32'(stall_count4), (m_stall > 15) ? 32'd15 : m_stall);
        chk("full_seen4", 32'(full_seen4), 32'(m_full));
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        wrst_n   = 1'b1;
        wfull    = 1'b0;
        stat_clr = 1'b0;
        #1 wrst_n = 1'b0;

        // 1. reset values, then ready after the first edge
        repeat (3) @(posedge wclk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_full_seen", 32'(full_seen), 32'd0);
        wrst_n = 1'b1;
        cyc();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // 2. back-to-back stream of 0x01..0x08
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        cyc();
        for (int i = 1; i <= 8; i++) begin
            chk("t2_winc", 32'(winc), 32'd1);
            chk("t2_wdata", 32'(wdata), 32'(i));
            cyc();
        end
        chk("t2_winc_end", 32'(winc), 32'd0);
        chk("t2_wr_count", 32'(wr_count), 32'd8);
        chk("t2_log_size", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) chk("t2_order", 32'(wlog[i]), 32'(i + 1));

        // 3. stall with wfull for four edges, then drain in order
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        chk("t3_clr", 32'(wr_count), 32'd0);
        wlog.delete();
        for (int i = 0; i < 6; i++) src.push_back(8'(8'h20 + i));
        wfull = 1'b1;
        cyc();
        cyc();
        chk("t3_ready_low", 32'(in_ready), 32'd0);
        cyc();
        cyc();
        chk("t3_stall", 32'(stall_count), 32'd3);
        chk("t3_full_seen", 32'(full_seen), 32'd1);
        chk("t3_winc", 32'(winc), 32'd0);
        wfull = 1'b0;
        wait_written(6, 40);
        cyc();
        cyc();
        chk("t3_log_size", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) chk("t3_order", 32'(wlog[i]), 32'(8'h20 + i));
        chk("t3_sticky", 32'(full_seen), 32'd1);

        // 4. wfull rises mid-cycle while winc is high
        wlog.delete();
        src.push_back(8'h30);
        cyc();
        chk("t4_winc_pre", 32'(winc), 32'd1);
        #2 wfull = 1'b1;
        #1;
        chk("t4_winc_drop", 32'(winc), 32'd0);
        chk("t4_wdata_hold", 32'(wdata), 32'h30);
        cyc();
        chk("t4_winc_held", 32'(winc), 32'd0);
        wfull = 1'b0;
        #1;
        chk("t4_winc_again", 32'(winc), 32'd1);
        cyc();
        cyc();
        chk("t4_log_size", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) chk("t4_word", 32'(wlog[0]), 32'h30);

        // 5. saturation of the 4-bit stall counter, then clear coincident with winc
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        wlog.delete();
        wfull = 1'b1;
        src.push_back(8'h40);
        repeat (25) cyc();
        chk("t5_stall16", 32'(stall_count), 32'd24);
        chk("t5_stall4_sat", 32'(stall_count4), 32'd15);
        wfull = 1'b0;
        wait_written(1, 10);
        wlog.delete();
        src.push_back(8'h50);
        src.push_back(8'h51);
        src.push_back(8'h52);
        cyc();
        chk("t5_winc_pre", 32'(winc), 32'd1);
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        chk("t5_clr_wins", 32'(wr_count), 32'd0);
        chk("t5_clr_wins4", 32'(wr_count4), 32'd0);
        chk("t5_clr_stall", 32'(stall_count), 32'd0);
        chk("t5_clr_full", 32'(full_seen), 32'd0);
        cyc();
        chk("t5_count_after", 32'(wr_count), 32'd1);
        wait_written(3, 10);

        // 6. reset while two words are held
        wlog.delete();
        wfull = 1'b1;
        src.push_back(8'hA1);
        src.push_back(8'hA2);
        cyc();
        cyc();
        chk("t6_two_ready", 32'(in_ready), 32'd0);
        wfull = 1'b0;
        #1;
        chk("t6_winc_pre", 32'(winc), 32'd1);
        chk("t6_wdata_pre", 32'(wdata), 32'hA1);
        wrst_n = 1'b0;
        #1;
        chk("t6_winc_rst", 32'(winc), 32'd0);
        chk("t6_ready_rst", 32'(in_ready), 32'd0);
        src.delete();
        cyc();
        cyc();
        wrst_n = 1'b1;
        cyc();
        chk("t6_ready_rel", 32'(in_ready), 32'd1);
        src.push_back(8'h10);
        src.push_back(8'h11);
        wait_written(2, 20);
        cyc();
        cyc();
        chk("t6_log_size", 32'(wlog.size()), 32'd2);
        if (wlog.size() > 1) begin
            chk("t6_word0", 32'(wlog[0]), 32'h10);
            chk("t6_word1", 32'(wlog[1]), 32'h11);
        end
        chk("t6_wr_count", 32'(wr_count), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
